// File: rtl/latch_bank_write_arbiter.sv
// Round-robin write arbiter and setup/enable/hold sequencer for a shared bank of
// level-sensitive D latches. Every output comes straight from a register.
module latch_bank_write_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned EN_CYCLES = 2
) (
  input  logic                   clk_in,
  input  logic                   reset_al_in,
  input  logic [N_REQ-1:0]       req_in,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  output logic [N_REQ-1:0]       grant_out,
  output logic [N_REQ-1:0]       ack_out,
  output logic [WIDTH-1:0]       latch_d_out,
  output logic                   latch_en_out,
  output logic                   busy_out
);

  localparam int unsigned PW = $clog2(N_REQ);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ENABLE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_ACK    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;

  logic             found;
  logic [PW-1:0]    pick;
  logic [PW:0]      idx;
  logic [WIDTH-1:0] pick_data;

  // Search from rr_q upward with wrap; first requester found wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(N_REQ)) begin
        idx = idx - (PW+1)'(N_REQ);
      end
      if (!found && req_in[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick == PW'(i)) begin
        pick_data = data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    grant_d = grant_q;
    ack_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d   = pick;
          data_d  = pick_data;
          grant_d = N_REQ'(1) << pick;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = 4'(EN_CYCLES - 1);
        state_d = S_ENABLE;
      end
      S_ENABLE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        // ack registered here so it is visible for exactly the ACK cycle
        ack_d   = grant_q;
        state_d = S_ACK;
      end
      S_ACK: begin
        grant_d = '0;
        rr_d    = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign en_d   = (state_d == S_ENABLE);
  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk_in) begin
    if (!reset_al_in) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_out    = grant_q;
  assign ack_out      = ack_q;
  assign latch_d_out  = data_q;
  assign latch_en_out = en_q;
  assign busy_out     = busy_q;

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// Self-checking bench for latch_bank_write_arbiter against a transaction-level
// round-robin model; k counts edges after the grant edge (k=0 is SETUP).
module tb_latch_bank_write_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int EN = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   grant, ack;
  logic [W-1:0]   ld;
  logic           len, busy;

  int checks   = 0;
  int failures = 0;
  int ptr      = 0;

  latch_bank_write_arbiter #(.WIDTH(W), .N_REQ(N), .EN_CYCLES(EN)) dut (
    .clk_in(clk), .reset_al_in(rst_n), .req_in(req), .data_in(data),
    .grant_out(grant), .ack_out(ack), .latch_d_out(ld),
    .latch_en_out(len), .busy_out(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int rr_pick(logic [N-1:0] r, int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] slice(logic [N*W-1:0] d, int i);
    return d[i*W +: W];
  endfunction

  task automatic test_reset();
    logic [W-1:0] exp_d;
    rst_n = 1'b0; req = '1; data = $urandom;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({grant, ack, len, busy, ld} !== '0) begin
        failures++;
        $display("FAIL reset_outputs: grant=%b ack=%b en=%b busy=%b d=%h required all 0", grant, ack, len, busy, ld);
      end
    end
    rst_n = 1'b1;
    exp_d = slice(data, 0);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || ld !== exp_d || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_grant: grant=%b d=%h busy=%b required 0001 %h 1", grant, ld, busy, exp_d);
    end
    req = '0;
    repeat (EN + 2) @(negedge clk);
    checks++;
    if (ack !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_ack: ack=%b required 0001", ack);
    end
    @(negedge clk);
    ptr = 1;
  endtask

  task automatic test_single();
    logic [N-1:0] e_g;
    data = $urandom; data[2*W +: W] = 8'hA5; req = 4'b0100;
    for (int k = 0; k <= EN + 3; k++) begin
      @(negedge clk);
      if (k == 0) req = '0;
      e_g = (k <= EN + 2) ? 4'b0100 : 4'b0000;
      checks++;
      if (grant !== e_g || ld !== 8'hA5) begin
        failures++;
        $display("FAIL single_grant_data k=%0d: grant=%b d=%h required %b a5", k, grant, ld, e_g);
      end
      checks++;
      if (len !== (k >= 1 && k <= EN) || ack !== ((k == EN + 2) ? 4'b0100 : 4'b0000)) begin
        failures++;
        $display("FAIL single_en_ack k=%0d: en=%b ack=%b", k, len, ack);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: busy=%b required 0", busy);
    end
    ptr = 3;
  endtask

  task automatic test_fairness();
    int w;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; ptr = 0; req = '1; data = $urandom;
    for (int g = 0; g < 5; g++) begin
      w = rr_pick(req, ptr);
      for (int k = 0; k <= EN + 3; k++) begin
        @(negedge clk);
        if (k == 0) begin
          checks++;
          if (grant !== (N'(1) << w) || ld !== slice(data, w)) begin
            failures++;
            $display("FAIL fairness_grant g=%0d: grant=%b d=%h required %b %h", g, grant, ld, N'(1) << w, slice(data, w));
          end
        end
        if (k == EN + 2) begin
          if (g == 4) req = '0;
        end
        if (k == EN + 3) begin
          checks++;
          if (grant !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL fairness_gap g=%0d: grant=%b busy=%b required 0 0", g, grant, busy);
          end
        end
      end
      ptr = (w + 1) % N;
    end
  endtask

  task automatic test_data_stability();
    int w;
    logic [W-1:0] exp_d;
    req = N'(1) << $urandom_range(0, N - 1); data = $urandom;
    w = rr_pick(req, ptr); exp_d = slice(data, w);
    for (int k = 0; k <= EN + 4; k++) begin
      @(negedge clk);
      if (k == EN + 2) req = '0;
      data = ~data;
      checks++;
      if (ld !== exp_d) begin
        failures++;
        $display("FAIL data_stability k=%0d: d=%h required %h", k, ld, exp_d);
      end
    end
    ptr = (w + 1) % N;
  endtask

  task automatic test_drop();
    int en_cnt = 0, ack_cnt = 0;
    req = 4'b1000; data = $urandom;
    for (int k = 0; k <= EN + 3; k++) begin
      @(negedge clk);
      if (k == 1) req = '0;
      if (len === 1'b1) en_cnt++;
      if (ack === 4'b1000) ack_cnt++;
    end
    checks++;
    if (en_cnt != EN || ack_cnt != 1) begin
      failures++;
      $display("FAIL drop: en_cycles=%0d acks=%0d required %0d 1", en_cnt, ack_cnt, EN);
    end
    ptr = 0;
  endtask

  task automatic test_reset_mid();
    req = 4'b0100; data = $urandom;
    @(negedge clk);
    req = '0;
    repeat (EN + 3) @(negedge clk);
    ptr = 3;
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    checks++;
    if (len !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_enable: en=%b required 1", len);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (len !== 1'b0 || grant !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_clear: en=%b grant=%b busy=%b required 0", len, grant, busy);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (ack !== '0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_noack c=%0d: ack=%b busy=%b required 0 0", c, ack, busy);
      end
    end
    ptr = 0;
    req = 4'b1001;
    @(negedge clk);
    req = '0;
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL reset_mid_rrptr: grant=%b required 0001", grant);
    end
    repeat (EN + 3) @(negedge clk);
    ptr = 1;
  endtask

  task automatic test_random();
    int w, gap;
    logic [W-1:0] exp_d;
    logic [N-1:0] oh, e_g, e_a;
    for (int t = 0; t < 25; t++) begin
      req  = N'($urandom_range(1, (1 << N) - 1));
      data = $urandom;
      w = rr_pick(req, ptr); exp_d = slice(data, w); oh = N'(1) << w;
      for (int k = 0; k <= EN + 3; k++) begin
        @(negedge clk);
        e_g = (k <= EN + 2) ? oh : '0;
        e_a = (k == EN + 2) ? oh : '0;
        checks++;
        if (grant !== e_g || ack !== e_a) begin
          failures++;
          $display("FAIL random_grant_ack t=%0d k=%0d: grant=%b ack=%b required %b %b", t, k, grant, ack, e_g, e_a);
        end
        checks++;
        if (len !== (k >= 1 && k <= EN) || busy !== (k <= EN + 2) || ld !== exp_d) begin
          failures++;
          $display("FAIL random_en_busy_d t=%0d k=%0d: en=%b busy=%b d=%h required d %h", t, k, len, busy, ld, exp_d);
        end
        if (k == 0) begin
          if ($urandom_range(0, 1) == 1) req = '0;
          data = $urandom;
        end
        if (k == EN + 2) req = '0;
      end
      ptr = (w + 1) % N;
      gap = $urandom_range(0, 2);
      for (int c = 0; c < gap; c++) begin
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ld !== exp_d) begin
          failures++;
          $display("FAIL random_idle_hold t=%0d: busy=%b d=%h required 0 %h", t, busy, ld, exp_d);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; data = '0;
    test_reset();
    test_single();
    test_fairness();
    test_data_stability();
    test_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/latch_bank_write_arbiter.md
# latch_bank_write_arbiter

Sequencer and arbiter for a shared WIDTH-bit bank of level-sensitive D latches. It accepts write requests from N_REQ requesters and picks one with round-robin priority. It then drives the bank's data and enable pins through a fixed setup / enable-pulse / hold sequence, so the latches never see data change while enable is high. It sits between the requesting logic and the latch bank's d/en inputs and is the only driver of those inputs.

## Interface
- WIDTH, 8: data width of the latch bank.
- N_REQ, 4: number of requesters; legal range 2..8.
- EN_CYCLES, 2: number of cycles the latch enable is held high; legal range 1..15.

- clk_in  input  1  single clock; all state updates on its rising edge.
- reset_al_in  input  1  reset, synchronous and active-low.
- req_in  input  N_REQ  per-requester write request, level; bit i belongs to requester i.
- data_in  input  N_REQ*WIDTH  requester i's data on bits [i*WIDTH +: WIDTH].
- grant_out  output  N_REQ  one-hot grant, high from SETUP through ACK inclusive.
- ack_out  output  N_REQ  one-cycle completion pulse to the granted requester, in ACK.
- latch_d_out  output  WIDTH  data to the latch bank d pins.
- latch_en_out  output  1  latch bank enable, high only in ENABLE.
- busy_out  output  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, SETUP, ENABLE, HOLD, ACK. All outputs are registered (Moore); no combinational path from inputs to outputs.
- IDLE:
  - If req_in is nonzero, select a winner round-robin: search starts at pointer rr_ptr, wraps modulo N_REQ, lowest index at or after rr_ptr wins.
  - On that edge: capture the winner's data_in slice into the data register, set grant_out to the winner's one-hot, go to SETUP.
  - If req_in is zero, stay in IDLE.
- SETUP (1 cycle): latch_d_out shows the captured data, latch_en_out is 0. Next state is ENABLE.
- ENABLE (EN_CYCLES cycles): latch_en_out is 1 and latch_d_out is held. A down-counter loaded with EN_CYCLES-1 on entry sets the length; at 0 the FSM goes to HOLD.
- HOLD (1 cycle): latch_en_out is 0 and latch_d_out is held. Next state is ACK.
- ACK (1 cycle):
  - ack_out is the winner's one-hot; grant_out stays asserted.
  - rr_ptr becomes (winner+1) mod N_REQ.
  - Next state is IDLE, with grant_out and ack_out cleared.
- Captured data is fixed at grant. Changes to data_in after the grant edge do not reach latch_d_out.
- If a requester drops req_in mid-transaction, the transaction still runs to ACK.
- Requesters keep req_in high until they see ack_out. A req_in still high in the IDLE cycle after ACK is a new request.
- latch_d_out holds its last value in IDLE; it is not cleared between transactions.

## Timing
- Reset (reset_al_in low at a rising edge) sets: state IDLE, rr_ptr 0, grant_out 0, ack_out 0, latch_en_out 0, latch_d_out 0, busy_out 0, counter 0.
- Reset mid-transaction: at the next edge latch_en_out goes to 0 and grant_out clears; no ack_out is issued.
- Latency, with req_in sampled high in IDLE at edge E:
  - grant_out, busy_out and latch_d_out are valid after E.
  - latch_en_out is high from E+1 to E+1+EN_CYCLES.
  - ack_out is high from E+2+EN_CYCLES to E+3+EN_CYCLES.
- Transaction length is EN_CYCLES+4 cycles from one IDLE sample to the next. Back-to-back throughput is one write per EN_CYCLES+4 cycles.
- Simultaneous requests are resolved by rr_ptr only. The requester that was just served has lowest priority in the next arbitration.
- Wrap-around: when the winner is N_REQ-1, rr_ptr becomes 0.
- Data is stable on latch_d_out for 1 cycle before the latch_en_out rise and 1 cycle after its fall.

## Test plan
- Reset: hold reset_al_in low 3 cycles with req_in=4'b1111 -> every output 0, no grant. Release reset -> requester 0 granted on the first edge.
- Single write, EN_CYCLES=2: req_in=4'b0100, data slice 2 = 8'hA5 -> grant_out=4'b0100 after E; latch_d_out=8'hA5 after E; latch_en_out high exactly 2 cycles from E+1; ack_out=4'b0100 for one cycle at E+4; IDLE at E+5.
- Fairness: hold req_in=4'b1111 continuously -> grants in the order 0,1,2,3,0, spaced 6 cycles apart.
- Data stability: toggle the granted requester's data_in every cycle during the transaction -> latch_d_out stays at the value captured at grant until the next grant.
- Requester drop: deassert req_in during ENABLE -> latch_en_out still runs its full EN_CYCLES and ack_out still pulses.
- Reset mid-ENABLE: assert reset_al_in low during the first ENABLE cycle -> latch_en_out is 0 and grant_out is 0 after the next edge; ack_out never pulses; rr_ptr returns to 0.
